uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (trmt / resp / tx_done) between NUM_REQ response sources, e.g. command processor, telemetry and error reporter.
- Round-robin arbitration with packet lock: a granted requester keeps the transmitter until its byte flagged last has been sent.
- A watchdog releases the grant if tx_done never arrives.
- Sits between the response sources and the UART wrapper's transmit inputs.

---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/rr_picker.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait
    } arb_state_t;

    localparam int unsigned DefaultTimeoutCycles = 65535;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, wrapping.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned IdxW = PtrW + 1;
    localparam logic [IdxW-1:0] NumReqI = IdxW'(NUM_REQ);

    logic [2*NUM_REQ-1:0] req_dbl;

    assign req_dbl = {req, req};

    always_comb begin
        logic [IdxW-1:0] idx;
        logic [IdxW-1:0] wrapped;
        winner  = '0;
        valid   = 1'b0;
        idx     = '0;
        wrapped = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx     = {1'b0, rr_ptr} + IdxW'(i);
            wrapped = (idx >= NumReqI) ? idx - NumReqI : idx;
            if (!valid && req_dbl[idx]) begin
                valid  = 1'b1;
                winner = wrapped[PtrW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ sources with round-robin packet-locked grants
// and a watchdog that releases a grant when tx_done never rises.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 trmt,
    output logic [7:0]           resp,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned PtrW  = $clog2(NUM_REQ);
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES - 1);
    localparam logic [PtrW-1:0]  PtrInit = PtrW'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PtrW-1:0]    gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               trmt_q, trmt_d;
    logic [7:0]         resp_q, resp_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WdogW-1:0]   wdog_q, wdog_d;
    logic               tx_done_q;
    logic               done_rise;

    logic [PtrW-1:0]    pick_idx;
    logic               pick_valid;
    logic [7:0]         req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req   (req),
        .rr_ptr(rr_ptr_q),
        .winner(pick_idx),
        .valid (pick_valid)
    );

    // Only the rising edge of the UART's level-type done is meaningful.
    assign done_rise = tx_done & ~tx_done_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ack_d     = '0;
        trmt_d    = 1'b0;
        resp_d    = resp_q;
        last_d    = last_q;
        err_d     = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        wdog_d    = wdog_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_idx_d       = pick_idx;
                    resp_d          = req_bytes[pick_idx];
                    last_d          = req_last[pick_idx];
                    trmt_d          = 1'b1;
                    ack_d           = gnt_d;
                    state_d         = StLoad;
                end
            end
            StLoad: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wdog_d = wdog_q + 1'b1;
                if (done_rise) begin
                    if (!last_q && req[gnt_idx_q]) begin
                        resp_d  = req_bytes[gnt_idx_q];
                        last_d  = req_last[gnt_idx_q];
                        trmt_d  = 1'b1;
                        ack_d   = gnt_q;
                        state_d = StLoad;
                    end else begin
                        // Packet finished or abandoned by its requester.
                        rr_ptr_d = gnt_idx_q;
                        gnt_d    = '0;
                        state_d  = StIdle;
                    end
                end else if (wdog_q == WdogMax) begin
                    err_d    = 1'b1;
                    rr_ptr_d = gnt_idx_q;
                    gnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ack_q     <= '0;
            trmt_q    <= 1'b0;
            resp_q    <= 8'h00;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            rr_ptr_q  <= PtrInit;
            wdog_q    <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ack_q     <= ack_d;
            trmt_q    <= trmt_d;
            resp_q    <= resp_d;
            last_q    <= last_d;
            err_q     <= err_d;
            rr_ptr_q  <= rr_ptr_d;
            wdog_q    <= wdog_d;
            tx_done_q <= tx_done;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign trmt = trmt_q;
    assign resp = resp_q;
    assign err  = err_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues bytes and expected transmissions, a monitor checks them.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } src_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] resp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [31:0]   req_data = '0;
    logic [NR-1:0] req_last = '0;
    logic [NR-1:0] gnt;
    logic [NR-1:0] ack;
    logic          trmt;
    logic [7:0]    resp;
    logic          tx_done = 1'b0;
    logic          busy;
    logic          err;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   uart_en = 1'b1;
    int   ack_cnt [NR];
    int   err_cnt = 0;
    src_t src_q [NR][$];
    exp_t sb [$];
    int   err_exp [$];

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .req_last(req_last),
        .gnt     (gnt),
        .ack     (ack),
        .trmt    (trmt),
        .resp    (resp),
        .tx_done (tx_done),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic push_src(input int i, input logic [7:0] d, input logic l);
        src_t e;
        e.data = d;
        e.last = l;
        src_q[i].push_back(e);
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [7:0] r);
        exp_t e;
        e.gnt  = g;
        e.resp = r;
        sb.push_back(e);
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(busy == 1'b0 && src_empty() && sb.size() == 0 && err_exp.size() == 0)
                   && n < budget);
        check(name, 32'(n < budget), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Requester model: presents the head of each source queue, advances on ack.
    initial begin
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (ack[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                req[i] = (src_q[i].size() != 0);
                if (src_q[i].size() != 0) begin
                    req_data[8*i +: 8] = src_q[i][0].data;
                    req_last[i]        = src_q[i][0].last;
                end
            end
        end
    end

    // UART model: done drops on trmt and rises five cycles later unless disabled.
    initial begin
        int cd = -1;
        forever begin
            @(negedge clk);
            if (trmt) begin
                tx_done = 1'b0;
                cd = uart_en ? 5 : -1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        logic trmt_prev = 1'b0;
        exp_t e;
        int   ec;
        forever begin
            @(negedge clk);
            if (trmt) begin
                if (sb.size() == 0) begin
                    fail("unexpected_trmt", $sformatf("resp %0h gnt %0b", resp, gnt));
                end else begin
                    e = sb.pop_front();
                    check("trmt_gnt", 32'(gnt), 32'(e.gnt));
                    check("trmt_resp", 32'(resp), 32'(e.resp));
                    check("trmt_ack", 32'(ack), 32'(e.gnt));
                end
            end else begin
                check("ack_without_trmt", 32'(ack), 0);
            end
            for (int i = 0; i < NR; i++) if (ack[i]) ack_cnt[i]++;
            if (err) begin
                err_cnt++;
                if (err_exp.size() == 0) begin
                    fail("unexpected_err", "err pulse with none pending");
                end else begin
                    ec = err_exp.pop_front();
                    check("err_cycle", 32'(cyc), 32'(ec));
                end
                check("err_gnt_clear", 32'(gnt), 0);
            end
            check("gnt_onehot0", 32'($onehot0(gnt)), 1);
            check("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
            check("trmt_b2b", 32'(trmt && trmt_prev), 0);
            trmt_prev = trmt;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a [NR];
        int k;
        int n;
        int e0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_trmt", 32'(trmt), 0);
        check("rst_resp", 32'(resp), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;

        // Single-byte packet from requester 0
        a[0] = ack_cnt[0];
        push_src(0, 8'hA5, 1'b1);
        push_exp(4'b0001, 8'hA5);
        wait_quiet("t1_quiet", 40);
        check("t1_ack0_once", 32'(ack_cnt[0] - a[0]), 1);
        check("t1_busy", 32'(busy), 0);

        // All four requesting: rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) a[i] = ack_cnt[i];
        push_src(0, 8'h10, 1'b1);
        push_src(0, 8'h14, 1'b1);
        push_src(1, 8'h11, 1'b1);
        push_src(2, 8'h12, 1'b1);
        push_src(3, 8'h13, 1'b1);
        push_exp(4'b0001, 8'h10);
        push_exp(4'b0010, 8'h11);
        push_exp(4'b0100, 8'h12);
        push_exp(4'b1000, 8'h13);
        push_exp(4'b0001, 8'h14);
        wait_quiet("t2_quiet", 120);
        check("t2_ack0", 32'(ack_cnt[0] - a[0]), 2);
        check("t2_ack1", 32'(ack_cnt[1] - a[1]), 1);
        check("t2_ack2", 32'(ack_cnt[2] - a[2]), 1);
        check("t2_ack3", 32'(ack_cnt[3] - a[3]), 1);

        // Locked 3-byte burst on requester 2 while requester 0 waits
        push_src(2, 8'h11, 1'b0);
        push_src(2, 8'h22, 1'b0);
        push_src(2, 8'h33, 1'b1);
        push_src(0, 8'h44, 1'b1);
        push_exp(4'b0100, 8'h11);
        push_exp(4'b0100, 8'h22);
        push_exp(4'b0100, 8'h33);
        push_exp(4'b0001, 8'h44);
        wait_quiet("t3_quiet", 120);

        // Watchdog: requester 1 granted, UART never completes
        uart_en = 1'b0;
        e0 = err_cnt;
        k = cyc;
        push_src(1, 8'h55, 1'b1);
        push_exp(4'b0010, 8'h55);
        err_exp.push_back(k + 18);
        wait_quiet("t4_quiet", 60);
        check("t4_err_once", 32'(err_cnt - e0), 1);
        uart_en = 1'b1;
        push_src(1, 8'h66, 1'b1);
        push_src(2, 8'h77, 1'b1);
        push_exp(4'b0100, 8'h77);
        push_exp(4'b0010, 8'h66);
        wait_quiet("t4b_quiet", 80);

        // Requester 3 drops req after the first of two bytes
        e0 = err_cnt;
        push_src(3, 8'h88, 1'b0);
        push_exp(4'b1000, 8'h88);
        wait_quiet("t5_quiet", 40);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_err", 32'(err_cnt - e0), 0);
        check("t5_idle", 32'(busy), 0);

        // Reset while waiting for tx_done; the late done edge must be ignored
        a[0] = ack_cnt[0];
        push_src(0, 8'h99, 1'b1);
        push_exp(4'b0001, 8'h99);
        n = 0;
        while (ack_cnt[0] == a[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_ack_seen", 32'(ack_cnt[0] - a[0]), 1);
        check("t6_busy_wait", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_rst_gnt", 32'(gnt), 0);
        check("t6_rst_trmt", 32'(trmt), 0);
        check("t6_rst_busy", 32'(busy), 0);
        a[0] = ack_cnt[0];
        repeat (10) @(posedge clk);
        #1;
        check("t6_stale_ack", 32'(ack_cnt[0] - a[0]), 0);
        check("t6_stale_busy", 32'(busy), 0);
        check("t6_tx_done_seen", 32'(tx_done), 1);

        check("sb_drained", 32'(sb.size()), 0);
        check("err_drained", 32'(err_exp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
